// File: rtl/tft_timing_gen_pkg.sv
// Shared definitions for the TFT timing generator.
// Holds the default panel timing, the per-axis total derivation, the
// phase-state encoding shared by both axis counters, and bus widths.
package tft_timing_gen_pkg;

  localparam int H_ACTIVE_DEF = 480;
  localparam int H_FP_DEF     = 2;
  localparam int H_SYNC_DEF   = 41;
  localparam int H_BP_DEF     = 2;

  localparam int V_ACTIVE_DEF = 272;
  localparam int V_FP_DEF     = 2;
  localparam int V_SYNC_DEF   = 10;
  localparam int V_BP_DEF     = 2;

  function automatic int axis_total(input int act, input int fp, input int sy, input int bp);
    return act + fp + sy + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  localparam int CNT_W  = 10;
  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

endpackage

// File: rtl/tft_axis_counter.sv
// One timing axis: position counter plus a 4-phase FSM.
//   state     | meaning
//   PH_ACTIVE | visible region, count 0 .. ACTIVE-1
//   PH_FP     | front porch
//   PH_SYNC   | sync pulse asserted
//   PH_BP     | back porch, ends at TOTAL-1 then wraps to 0
// Ports: CLK, nRESET (async, active-low); en (0 clears to idle at the
// next CLK); adv (advance one step); count; wrap (advancing past
// TOTAL-1 this cycle); active / sync (current phase flags).
module tft_axis_counter
  import tft_timing_gen_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             en,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] END_BP   = CNT_W'(TOTAL - 1);

  phase_t           state, state_nxt;
  logic [CNT_W-1:0] count_nxt;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state <= PH_ACTIVE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (!en) begin
      state_nxt = PH_ACTIVE;
      count_nxt = '0;
    end else if (adv) begin
      count_nxt = (count == END_BP) ? '0 : count + 1'b1;
      case (state)
        PH_ACTIVE: if (count == END_ACT)  state_nxt = PH_FP;
        PH_FP:     if (count == END_FP)   state_nxt = PH_SYNC;
        PH_SYNC:   if (count == END_SYNC) state_nxt = PH_BP;
        PH_BP:     if (count == END_BP)   state_nxt = PH_ACTIVE;
        default:                          state_nxt = PH_ACTIVE;
      endcase
    end
  end

  assign wrap   = en & adv & (count == END_BP);
  assign active = (state == PH_ACTIVE);
  assign sync   = (state == PH_SYNC);

endmodule

// File: rtl/tft_timing_gen.sv
// TFT panel timing generator with frame-buffer fetch.
// Stage 0: horizontal/vertical axis counters and the read address.
// Stage 1: registered DE/syncs/FRAME_START, aligned with the 1-CLK BRAM
// read latency so R/G/B can be gated straight from the BRAM data.
// Ports: CLK, nRESET (async, active-low), EN (run enable);
// BRAM_R/G/B in, BRAMADDR out; Hsync, Vsync, DE, R, G, B panel outputs;
// H_COUNT/V_COUNT stage-0 position; FRAME_START first-pixel pulse.
module tft_timing_gen
  import tft_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              EN,
  input  logic [7:0]        BRAM_R,
  input  logic [7:0]        BRAM_G,
  input  logic [7:0]        BRAM_B,
  output logic [ADDR_W-1:0] BRAMADDR,
  output logic              Hsync,
  output logic              Vsync,
  output logic              DE,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic [CNT_W-1:0]  H_COUNT,
  output logic [CNT_W-1:0]  V_COUNT,
  output logic              FRAME_START
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic h_wrap, h_active, h_sync;
  logic v_wrap, v_active, v_sync;
  logic hde, origin;

  tft_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .CLK    (CLK),
    .nRESET (nRESET),
    .en     (EN),
    .adv    (1'b1),
    .count  (H_COUNT),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  tft_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .CLK    (CLK),
    .nRESET (nRESET),
    .en     (EN),
    .adv    (h_wrap),
    .count  (V_COUNT),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (v_sync)
  );

  assign hde    = h_active & v_active;
  assign origin = (H_COUNT == '0) && (V_COUNT == '0);

  // The address already points at the next pixel to fetch, so it stops
  // at the last pixel instead of running one past the frame.
  // v_wrap implies h_wrap, so it alone marks the return to (0,0).
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      BRAMADDR <= '0;
    end else if (!EN || v_wrap) begin
      BRAMADDR <= '0;
    end else if (hde && (BRAMADDR != ADDR_MAX)) begin
      BRAMADDR <= BRAMADDR + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      DE          <= 1'b0;
      Hsync       <= ~SYNC_POL;
      Vsync       <= ~SYNC_POL;
      FRAME_START <= 1'b0;
    end else if (!EN) begin
      DE          <= 1'b0;
      Hsync       <= ~SYNC_POL;
      Vsync       <= ~SYNC_POL;
      FRAME_START <= 1'b0;
    end else begin
      DE          <= hde;
      Hsync       <= h_sync ? SYNC_POL : ~SYNC_POL;
      Vsync       <= v_sync ? SYNC_POL : ~SYNC_POL;
      FRAME_START <= hde & origin;
    end
  end

  assign R = DE ? BRAM_R : 8'h00;
  assign G = DE ? BRAM_G : 8'h00;
  assign B = DE ? BRAM_B : 8'h00;

endmodule

// File: doc/tft_timing_gen.md
TFT_TIMING_GEN -- requirements
Module: tft_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 2, horizontal front-porch clocks.
REQ-003 SHALL have parameter H_SYNC, default 41, Hsync pulse clocks.
REQ-004 SHALL have parameter H_BP, default 2, horizontal back-porch clocks (H_TOTAL = 525).
REQ-005 SHALL have parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 272/2/10/2, all in lines (V_TOTAL = 286).
REQ-006 SHALL have parameter SYNC_POL, default 0, giving the asserted sync level.
REQ-007 SHALL have port CLK, input, 1, pixel clock; the block uses one clock only.
REQ-008 SHALL have port nRESET, input, 1, reset that is asynchronous and active-low.
REQ-009 SHALL have port EN, input, 1, run enable.
REQ-010 SHALL have ports BRAM_R, BRAM_G and BRAM_B, input, 8 each, frame-buffer read data returned one CLK after BRAMADDR.
REQ-011 SHALL have port BRAMADDR, output, 17, frame-buffer read address.
REQ-012 SHALL have ports Hsync and Vsync, output, 1 each, sync outputs.
REQ-013 SHALL have port DE, output, 1, data enable.
REQ-014 SHALL have ports R, G and B, output, 8 each, pixel data.
REQ-015 SHALL have ports H_COUNT and V_COUNT, output, 10 each, stage-0 position counters.
REQ-016 SHALL have port FRAME_START, output, 1, one-clock pulse aligned with the first DE of each frame.

Function
REQ-017 Stage 0: H_COUNT SHALL count 0..H_TOTAL-1 and then wrap to 0.
REQ-018 V_COUNT SHALL increment only on the H wrap and SHALL wrap to 0 after V_TOTAL-1.
REQ-019 Horizontal phases SHALL be, in order: ACTIVE [0, H_ACTIVE-1], FP, SYNC, BP; vertical phases SHALL follow the same order, in lines.
REQ-020 Each axis SHALL be a 4-state FSM (ACTIVE, FP, SYNC, BP) with transitions at the parameter boundaries; no illegal state is reachable.
REQ-021 Stage-0 hDE SHALL equal (h in ACTIVE) AND (v in ACTIVE).
REQ-022 BRAMADDR SHALL present the address of the pixel at (H_COUNT, V_COUNT) whenever hDE=1.
REQ-023 BRAMADDR SHALL increment by 1 per active pixel and SHALL never exceed H_ACTIVE*V_ACTIVE-1 (130559).
REQ-024 BRAMADDR SHALL return to 0 when the stage-0 counters wrap to (0,0).
REQ-025 BRAMADDR SHALL hold its value during blanking.
REQ-026 Stage 1 SHALL register the stage-0 sync and DE signals, so Hsync, Vsync and DE lag the counters by exactly 1 CLK, matching the 1-CLK BRAM latency.
REQ-027 R, G and B SHALL equal BRAM_R, BRAM_G and BRAM_B when DE=1, and 8'h00 when DE=0.
REQ-028 Hsync SHALL equal SYNC_POL exactly while the horizontal FSM is in SYNC (delayed 1 CLK), and ~SYNC_POL otherwise; Vsync SHALL behave the same for the vertical FSM.
REQ-029 FRAME_START SHALL be 1 for the single stage-1 cycle corresponding to stage-0 (0,0).
REQ-030 EN=0 SHALL return the block, at the next CLK, to idle: counters 0, BRAMADDR 0, DE 0, syncs at ~SYNC_POL, RGB 0, FRAME_START 0.
REQ-031 EN=0 SHALL be honoured mid-line and mid-frame with no completion of the current frame.
REQ-032 On EN 0->1, the first enabled CLK SHALL be stage-0 (0,0), and the first DE and FRAME_START SHALL appear 1 CLK later.
REQ-033 When the H wrap and the V wrap coincide, both counters SHALL become 0 in the same cycle and BRAMADDR SHALL become 0.

Reset
REQ-034 nRESET low SHALL asynchronously force: H_COUNT 0, V_COUNT 0, BRAMADDR 0, both FSMs ACTIVE, DE 0, Hsync and Vsync at ~SYNC_POL, R/G/B 0, FRAME_START 0.
REQ-035 Deassertion of nRESET SHALL be followed, with EN=1, by behaviour identical to REQ-032.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately, with no partial pulse extension.

Structure
REQ-037 A shared package SHALL hold the timing defaults, H_TOTAL and V_TOTAL derivations, the phase-state encoding, and the address width (17).
REQ-038 One sub-module, tft_axis_counter, SHALL implement a single axis (counter, 4-state FSM, wrap/sync/active flags) and SHALL be instantiated twice, with the vertical instance advanced by the horizontal wrap.

Verification
REQ-039 Reset, then EN=1 -> first DE at CLK 1; DE high for 480 CLKs per line; Hsync low for 41 CLKs, starting at stage-0 H_COUNT=482 (output CLK 483).
REQ-040 Run 2 full frames -> 286 lines/frame, Vsync low for 10 lines, 130560 DE cycles per frame, FRAME_START pulse spacing 150150 CLKs.
REQ-041 BRAM model returning R=addr[7:0], G=addr[15:8], B={7'b0,addr[16]} -> R/G/B match the address for every DE; last address 130559; RGB=0 during blanking.
REQ-042 EN dropped at V_COUNT=100, H_COUNT=200 for 5 CLKs -> idle outputs next CLK; restart resumes at (0,0) with BRAMADDR 0.
REQ-043 nRESET pulsed asynchronously mid-Hsync -> outputs reach reset values without a CLK edge; no glitch pulse after release.
REQ-044 SYNC_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=V_ACTIVE=V_FP=V_SYNC=V_BP=1 -> line total 11 CLKs, frame total 4 lines, syncs active-high, simultaneous H/V wrap handled per REQ-033.
